pc_bus_arbiter: RTL and testbench

Bus-ownership and ready sequencer for the PC system bus. Arbitrates between the 8088 CPU and the 8237 DMA controller, producing the hold acknowledge and the active-low address enable that hands the bus over. Inserts I/O wait states and merges the channel-ready line into the `rdy1`/`aen1` pair consumed by the `intel8284a` clock generator. Sits between the CPU status decode, the DMA controller and the clock generator.

---
 rtl/pc_bus_pkg.sv | 16 +
 rtl/rdy_timer.sv | 70 +++++++
 rtl/pc_bus_arbiter.sv | 112 +++++++++++
 tb/tb_pc_bus_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pc_bus_pkg.sv
// Shared types and parameter defaults for the PC system-bus arbiter.
package pc_bus_pkg;

  typedef enum logic [2:0] {
    ST_CPU      = 3'd0,
    ST_SYNC     = 3'd1,
    ST_DEAD_IN  = 3'd2,
    ST_DMA      = 3'd3,
    ST_DEAD_OUT = 3'd4
  } bus_st_t;

  localparam int unsigned IO_WAIT_DEF  = 1;
  localparam int unsigned DEAD_CYC_DEF = 1;
  localparam int unsigned TMO_CYC_DEF  = 255;

endpackage

// File: rtl/rdy_timer.sv
// I/O wait-state counter and channel-ready timeout; produces the registered
// rdy1 line and a one-cycle timeout pulse.
module rdy_timer #(
  parameter int unsigned IO_WAIT = pc_bus_pkg::IO_WAIT_DEF,
  parameter int unsigned TMO_CYC = pc_bus_pkg::TMO_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_io_start,
  input  logic i_io_chrdy,
  output logic o_rdy1,
  output logic o_wcnt_busy_c,
  output logic o_tmo_set_c
);

  localparam int unsigned WW       = (IO_WAIT > 0) ? $clog2(IO_WAIT + 1) : 1;
  localparam int unsigned TW_RAW   = $clog2(TMO_CYC + 1);
  localparam int unsigned TW       = (TW_RAW < 8) ? 8 : TW_RAW;
  localparam int unsigned TMO_LAST = (TMO_CYC > 0) ? TMO_CYC - 1 : 0;

  logic [WW-1:0] r_wcnt;
  logic [WW-1:0] w_wcnt_nxt;
  logic [TW-1:0] r_tcnt;
  logic [TW-1:0] w_tcnt_nxt;
  logic          r_rdy1;
  logic          w_rdy1_d;
  logic          w_tmo_force;

  // Timeout fires on the cycle the count would reach TMO_CYC.
  assign w_tmo_force = !i_io_chrdy && (r_wcnt == '0) && (r_tcnt == TW'(TMO_LAST));

  always_comb begin
    w_wcnt_nxt = r_wcnt;
    if (i_io_start) begin
      w_wcnt_nxt = WW'(IO_WAIT);
    end else if (r_wcnt != '0) begin
      w_wcnt_nxt = r_wcnt - WW'(1);
    end
  end

  // Only cycles stretched purely by io_chrdy count toward the timeout.
  always_comb begin
    w_tcnt_nxt = r_tcnt;
    if (i_io_chrdy || w_tmo_force) begin
      w_tcnt_nxt = '0;
    end else if (r_wcnt == '0) begin
      w_tcnt_nxt = r_tcnt + TW'(1);
    end
  end

  // rdy1 is registered from next-cycle wait count so it lines up with wcnt.
  assign w_rdy1_d = !((w_wcnt_nxt != '0) || (!i_io_chrdy && !w_tmo_force));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt <= '0;
      r_tcnt <= '0;
      r_rdy1 <= 1'b1;
    end else begin
      r_wcnt <= w_wcnt_nxt;
      r_tcnt <= w_tcnt_nxt;
      r_rdy1 <= w_rdy1_d;
    end
  end

  assign o_rdy1        = r_rdy1;
  assign o_wcnt_busy_c = (r_wcnt != '0);
  assign o_tmo_set_c   = w_tmo_force;

endmodule

// File: rtl/pc_bus_arbiter.sv
// CPU/DMA bus-ownership sequencer with dead-time insertion, feeding the
// hold acknowledge, aen1 and rdy1 lines of the PC system bus.
module pc_bus_arbiter #(
  parameter int unsigned IO_WAIT  = pc_bus_pkg::IO_WAIT_DEF,
  parameter int unsigned DEAD_CYC = pc_bus_pkg::DEAD_CYC_DEF,
  parameter int unsigned TMO_CYC  = pc_bus_pkg::TMO_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic hrq,
  input  logic cpu_idle,
  input  logic io_start,
  input  logic io_chrdy,
  output logic hlda,
  output logic aen1,
  output logic rdy1,
  output logic bus_tmo
);

  import pc_bus_pkg::*;

  localparam int unsigned DW        = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam int unsigned DEAD_LAST = (DEAD_CYC > 0) ? DEAD_CYC - 1 : 0;

  bus_st_t       r_st;
  bus_st_t       w_st_nxt;
  logic [DW-1:0] r_dcnt;
  logic          w_dead_done;
  logic          r_hlda;
  logic          r_aen1;
  logic          r_bus_tmo;
  logic          w_hlda_d;
  logic          w_aen1_d;
  logic          w_wcnt_busy;
  logic          w_tmo_set;
  logic          w_io_start_q;

  assign w_io_start_q = io_start && (r_st == ST_CPU);
  assign w_dead_done  = (r_dcnt == DW'(DEAD_LAST));

  rdy_timer #(
    .IO_WAIT (IO_WAIT),
    .TMO_CYC (TMO_CYC)
  ) u_rdy_timer (
    .clk           (clk),
    .reset         (reset),
    .i_io_start    (w_io_start_q),
    .i_io_chrdy    (io_chrdy),
    .o_rdy1        (rdy1),
    .o_wcnt_busy_c (w_wcnt_busy),
    .o_tmo_set_c   (w_tmo_set)
  );

  // State register plus registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st      <= ST_CPU;
      r_hlda    <= 1'b0;
      r_aen1    <= 1'b1;
      r_bus_tmo <= 1'b0;
    end else begin
      r_st      <= w_st_nxt;
      r_hlda    <= w_hlda_d;
      r_aen1    <= w_aen1_d;
      r_bus_tmo <= r_bus_tmo | w_tmo_set;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (w_st_nxt != r_st)) begin
      r_dcnt <= '0;
    end else if ((r_st == ST_DEAD_IN) || (r_st == ST_DEAD_OUT)) begin
      r_dcnt <= r_dcnt + DW'(1);
    end
  end

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      ST_CPU:      if (hrq) w_st_nxt = ST_SYNC;
      ST_SYNC: begin
        if (!hrq) begin
          w_st_nxt = ST_CPU;
        end else if (cpu_idle && !w_wcnt_busy) begin
          w_st_nxt = ST_DEAD_IN;
        end
      end
      ST_DEAD_IN:  if (w_dead_done) w_st_nxt = ST_DMA;
      ST_DMA:      if (!hrq) w_st_nxt = ST_DEAD_OUT;
      ST_DEAD_OUT: if (w_dead_done) w_st_nxt = ST_CPU;
      default:     w_st_nxt = ST_CPU;
    endcase
  end

  always_comb begin
    w_hlda_d = 1'b0;
    w_aen1_d = 1'b1;
    case (w_st_nxt)
      ST_DEAD_IN, ST_DEAD_OUT: w_aen1_d = 1'b0;
      ST_DMA: begin
        w_hlda_d = 1'b1;
        w_aen1_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign hlda    = r_hlda;
  assign aen1    = r_aen1;
  assign bus_tmo = r_bus_tmo;

endmodule

// File: tb/tb_pc_bus_arbiter.sv
// Vector/scoreboard bench for pc_bus_arbiter: each row gives one cycle of
// inputs and the outputs expected after the following clock edge.
module tb_pc_bus_arbiter;

  typedef struct {
    string tag;
    logic  rst, hrq, idle, ios, chr;
    logic  hlda, aen1, rdy1, tmo;
  } vec_t;

  typedef struct {
    string tag;
    int    idx;
    logic  hlda, aen1, rdy1, tmo;
  } exp_t;

  logic clk;
  logic reset;
  logic hrq;
  logic cpu_idle;
  logic io_start;
  logic io_chrdy;
  logic hlda;
  logic aen1;
  logic rdy1;
  logic bus_tmo;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  pc_bus_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .hrq      (hrq),
    .cpu_idle (cpu_idle),
    .io_start (io_start),
    .io_chrdy (io_chrdy),
    .hlda     (hlda),
    .aen1     (aen1),
    .rdy1     (rdy1),
    .bus_tmo  (bus_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string tag, input logic rst, input logic h, input logic idl,
                     input logic ios, input logic chr, input logic e_hlda,
                     input logic e_aen1, input logic e_rdy1, input logic e_tmo);
    vec_t v;
    v.tag = tag; v.rst = rst; v.hrq = h; v.idle = idl; v.ios = ios; v.chr = chr;
    v.hlda = e_hlda; v.aen1 = e_aen1; v.rdy1 = e_rdy1; v.tmo = e_tmo;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int idx, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %b, want %b", nm, idx, act, exp);
    end
  endtask

  // Drive one row, queue its expectation, then compare after the edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    reset    = v.rst;
    hrq      = v.hrq;
    cpu_idle = v.idle;
    io_start = v.ios;
    io_chrdy = v.chr;
    e.tag = v.tag; e.idx = idx;
    e.hlda = v.hlda; e.aen1 = v.aen1; e.rdy1 = v.rdy1; e.tmo = v.tmo;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", idx, 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, ".hlda"},    e.idx, hlda,    e.hlda);
      check({e.tag, ".aen1"},    e.idx, aen1,    e.aen1);
      check({e.tag, ".rdy1"},    e.idx, rdy1,    e.rdy1);
      check({e.tag, ".bus_tmo"}, e.idx, bus_tmo, e.tmo);
    end
  endtask

  initial begin
    reset = 1'b1; hrq = 1'b0; cpu_idle = 1'b1; io_start = 1'b0; io_chrdy = 1'b1;

    //   tag          rst hrq idl ios chr  hlda aen1 rdy1 tmo
    add("reset",       1,  1,  1,  0,  1,   0,   1,   1,   0);
    add("reset",       1,  1,  1,  0,  1,   0,   1,   1,   0);
    add("idle",        0,  0,  1,  0,  1,   0,   1,   1,   0);
    add("idle",        0,  0,  1,  0,  1,   0,   1,   1,   0);
    add("grant",       0,  1,  1,  0,  1,   0,   1,   1,   0);
    add("grant",       0,  1,  1,  0,  1,   0,   0,   1,   0);
    add("grant",       0,  1,  1,  0,  1,   1,   0,   1,   0);
    add("dma_ios",     0,  1,  1,  1,  1,   1,   0,   1,   0);
    add("dma_chrdy",   0,  1,  1,  0,  0,   1,   0,   0,   0);
    add("dma_chrdy",   0,  1,  1,  0,  1,   1,   0,   1,   0);
    add("release",     0,  0,  1,  0,  1,   0,   0,   1,   0);
    add("release",     0,  1,  1,  0,  1,   0,   1,   1,   0);
    add("abort",       0,  1,  0,  0,  1,   0,   1,   1,   0);
    add("abort",       0,  0,  1,  0,  1,   0,   1,   1,   0);
    add("abort",       0,  0,  1,  0,  1,   0,   1,   1,   0);
    add("iowait",      0,  0,  1,  1,  1,   0,   1,   0,   0);
    add("iowait",      0,  0,  1,  0,  1,   0,   1,   1,   0);
    add("chrdy",       0,  0,  1,  1,  1,   0,   1,   0,   0);
    add("chrdy",       0,  0,  1,  0,  0,   0,   1,   0,   0);
    add("chrdy",       0,  0,  1,  0,  0,   0,   1,   0,   0);
    add("chrdy",       0,  0,  1,  0,  0,   0,   1,   0,   0);
    add("chrdy",       0,  0,  1,  0,  0,   0,   1,   0,   0);
    add("chrdy",       0,  0,  1,  0,  1,   0,   1,   1,   0);
    add("blocked",     0,  1,  0,  1,  1,   0,   1,   0,   0);
    add("blocked",     0,  1,  0,  1,  1,   0,   1,   1,   0);
    add("blocked",     0,  1,  0,  0,  1,   0,   1,   1,   0);
    add("blocked",     0,  1,  1,  0,  1,   0,   0,   1,   0);
    add("blocked",     0,  1,  1,  0,  1,   1,   0,   1,   0);
    add("blocked",     0,  0,  1,  0,  1,   0,   0,   1,   0);
    add("blocked",     0,  0,  1,  0,  1,   0,   1,   1,   0);
    add("io_wins",     0,  1,  1,  1,  1,   0,   1,   0,   0);
    add("io_wins",     0,  1,  1,  0,  1,   0,   1,   1,   0);
    add("io_wins",     0,  1,  1,  0,  1,   0,   0,   1,   0);
    add("io_wins",     0,  1,  1,  0,  1,   1,   0,   1,   0);
    add("rst_dma",     0,  1,  1,  0,  1,   1,   0,   1,   0);
    add("rst_dma",     1,  1,  1,  0,  1,   0,   1,   1,   0);
    add("rst_dma",     0,  0,  1,  0,  1,   0,   1,   1,   0);

    // Channel-ready timeout: wcnt clears after the first held cycle, then
    // 255 counted cycles release rdy1 for exactly one cycle.
    add("tmo_start",   0,  0,  1,  1,  1,   0,   1,   0,   0);
    for (int k = 1; k <= 300; k++) begin
      add("tmo",       0,  0,  1,  0,  0,   0,   1,   (k == 256), (k >= 256));
    end
    add("tmo_end",     0,  0,  1,  0,  1,   0,   1,   1,   1);
    add("tmo_sticky",  0,  1,  1,  0,  1,   0,   1,   1,   1);
    add("tmo_rst",     1,  0,  1,  0,  1,   0,   1,   1,   0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    if (exp_q.size() != 0) begin
      check("scoreboard_leftover", 0, 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
